// File: rtl/eth_ident_table.sv
// eth_ident_table
//   Per-port Ethernet identity table (MAC / IPv4 / UDP CHDR port) with
//   NUM_IDS independently enabled entries. Register writes land in a shadow
//   copy; a COMMIT write moves the whole shadow copy into the active copy at
//   a packet boundary of the monitored RX stream, or immediately when forced.
//   A one-cycle registered lookup port matches header fields against the
//   active copy.
//
//   Handshake semantics: the register bus is strobe based (reg_wr_req /
//   reg_rd_req sampled on the rising edge; reg_rd_resp is a single-cycle
//   pulse one cycle after a mapped read). The packet taps count a beat only
//   when pkt_tvalid and pkt_tready are both high on a rising edge. lkp_req
//   may be asserted every cycle; lkp_resp follows one cycle later.
//
// Ports
//   clk, reset                         clock, synchronous active-high reset
//   reg_wr_req/addr/data               register write
//   reg_rd_req/addr, reg_rd_resp/data  register read
//   pkt_tvalid/tready/tlast            RX stream monitor taps
//   lkp_req, lkp_mac/ip/udp            lookup request
//   lkp_resp, lkp_hit, lkp_mac_hit,
//   lkp_idx                            registered lookup result
//   active_mac/ip/udp, active_en       flattened active table (entry i at slice i)

module eth_ident_table #(
  parameter int unsigned NUM_IDS     = 2,
  parameter int unsigned REG_AWIDTH  = 14,
  parameter int unsigned BASE        = 0,
  parameter logic [47:0] DEFAULT_MAC = 48'h00802f16c52f,
  parameter logic [31:0] DEFAULT_IP  = 32'hC0A8010A,
  parameter logic [15:0] DEFAULT_UDP = 16'd49153
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    reg_wr_req,
  input  logic [REG_AWIDTH-1:0]   reg_wr_addr,
  input  logic [31:0]             reg_wr_data,
  input  logic                    reg_rd_req,
  input  logic [REG_AWIDTH-1:0]   reg_rd_addr,
  output logic                    reg_rd_resp,
  output logic [31:0]             reg_rd_data,
  input  logic                    pkt_tvalid,
  input  logic                    pkt_tready,
  input  logic                    pkt_tlast,
  input  logic                    lkp_req,
  input  logic [47:0]             lkp_mac,
  input  logic [31:0]             lkp_ip,
  input  logic [15:0]             lkp_udp,
  output logic                    lkp_resp,
  output logic                    lkp_hit,
  output logic                    lkp_mac_hit,
  output logic [2:0]              lkp_idx,
  output logic [48*NUM_IDS-1:0]   active_mac,
  output logic [32*NUM_IDS-1:0]   active_ip,
  output logic [16*NUM_IDS-1:0]   active_udp,
  output logic [NUM_IDS-1:0]      active_en
);

  localparam logic [REG_AWIDTH-1:0] BASE_A      = REG_AWIDTH'(BASE);
  localparam logic [REG_AWIDTH-1:0] ENTRY_LIMIT = REG_AWIDTH'(32'h1000);
  localparam logic [REG_AWIDTH-1:0] COMMIT_OFF  = REG_AWIDTH'(32'h1000);
  localparam logic [REG_AWIDTH-1:0] STATUS_OFF  = REG_AWIDTH'(32'h1004);

  // Shadow (software-visible) and active (lookup-visible) copies
  logic [47:0]        sh_mac  [NUM_IDS];
  logic [31:0]        sh_ip   [NUM_IDS];
  logic [15:0]        sh_udp  [NUM_IDS];
  logic [NUM_IDS-1:0] sh_en;
  logic [47:0]        act_mac [NUM_IDS];
  logic [31:0]        act_ip  [NUM_IDS];
  logic [15:0]        act_udp [NUM_IDS];
  logic [NUM_IDS-1:0] act_en;

  logic       in_pkt;
  logic       pending;
  logic [7:0] commit_cnt;

  // ---------------- Address decode ----------------
  // One extra bit on the subtraction tells whether the address is below BASE.
  logic [REG_AWIDTH:0]   wr_diff, rd_diff;
  logic [REG_AWIDTH-1:0] wr_off, rd_off;
  logic                  wr_in_win, rd_in_win;
  logic [6:0]            wr_idx, rd_idx;
  logic [4:0]            wr_sub, rd_sub;
  logic                  wr_entry, commit_wr;

  assign wr_diff   = {1'b0, reg_wr_addr} - {1'b0, BASE_A};
  assign rd_diff   = {1'b0, reg_rd_addr} - {1'b0, BASE_A};
  assign wr_off    = wr_diff[REG_AWIDTH-1:0];
  assign rd_off    = rd_diff[REG_AWIDTH-1:0];
  assign wr_in_win = ~wr_diff[REG_AWIDTH];
  assign rd_in_win = ~rd_diff[REG_AWIDTH];
  assign wr_idx    = wr_off[11:5];
  assign rd_idx    = rd_off[11:5];
  assign wr_sub    = wr_off[4:0];
  assign rd_sub    = rd_off[4:0];
  assign wr_entry  = reg_wr_req && wr_in_win && (wr_off < ENTRY_LIMIT);
  assign commit_wr = reg_wr_req && wr_in_win && (wr_off == COMMIT_OFF);

  // ---------------- Commit control ----------------
  logic beat, commit_req, commit_force, commit_apply;

  assign beat         = pkt_tvalid && pkt_tready;
  assign commit_req   = commit_wr && reg_wr_data[0];
  assign commit_force = commit_wr && reg_wr_data[1];
  // Non-forced commits wait for an edge with no packet open and no beat moving.
  assign commit_apply = commit_force || (pending && !in_pkt && !beat);

  always_ff @(posedge clk) begin
    if (reset) begin
      in_pkt     <= 1'b0;
      pending    <= 1'b0;
      commit_cnt <= 8'd0;
    end else begin
      if (beat) in_pkt <= !pkt_tlast;
      // Applying always clears pending, so a request that arrives on the
      // apply edge folds into this application.
      if (commit_apply) begin
        pending    <= 1'b0;
        commit_cnt <= commit_cnt + 8'd1;
      end else if (commit_req) begin
        pending <= 1'b1;
      end
    end
  end

  // ---------------- Shadow and active copies ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_IDS; i++) begin
        sh_mac[i]  <= DEFAULT_MAC;
        sh_ip[i]   <= (i == 0) ? DEFAULT_IP : 32'd0;
        sh_udp[i]  <= DEFAULT_UDP;
        sh_en[i]   <= (i == 0);
        act_mac[i] <= DEFAULT_MAC;
        act_ip[i]  <= (i == 0) ? DEFAULT_IP : 32'd0;
        act_udp[i] <= DEFAULT_UDP;
        act_en[i]  <= (i == 0);
      end
    end else begin
      // The active copy takes the pre-edge shadow values, so a shadow write
      // on the apply edge is not part of this commit.
      if (commit_apply) begin
        for (int i = 0; i < NUM_IDS; i++) begin
          act_mac[i] <= sh_mac[i];
          act_ip[i]  <= sh_ip[i];
          act_udp[i] <= sh_udp[i];
          act_en[i]  <= sh_en[i];
        end
      end
      if (wr_entry) begin
        for (int i = 0; i < NUM_IDS; i++) begin
          if (wr_idx == 7'(i)) begin
            case (wr_sub)
              5'h00:   sh_mac[i][31:0]  <= reg_wr_data;
              5'h04:   sh_mac[i][47:32] <= reg_wr_data[15:0];
              5'h08:   sh_ip[i]         <= reg_wr_data;
              5'h0C:   sh_udp[i]        <= reg_wr_data[15:0];
              5'h10:   sh_en[i]         <= reg_wr_data[0];
              default: ;
            endcase
          end
        end
      end
    end
  end

  // ---------------- Register read ----------------
  logic        rd_hit;
  logic [31:0] rd_val;

  always_comb begin
    rd_hit = 1'b0;
    rd_val = 32'd0;
    if (rd_in_win) begin
      if (rd_off == STATUS_OFF) begin
        rd_hit = 1'b1;
        rd_val = {16'd0, commit_cnt, 7'd0, pending};
      end else if (rd_off < ENTRY_LIMIT) begin
        for (int i = 0; i < NUM_IDS; i++) begin
          if (rd_idx == 7'(i)) begin
            case (rd_sub)
              5'h00: begin rd_hit = 1'b1; rd_val = sh_mac[i][31:0]; end
              5'h04: begin rd_hit = 1'b1; rd_val = {16'd0, sh_mac[i][47:32]}; end
              5'h08: begin rd_hit = 1'b1; rd_val = sh_ip[i]; end
              5'h0C: begin rd_hit = 1'b1; rd_val = {16'd0, sh_udp[i]}; end
              5'h10: begin rd_hit = 1'b1; rd_val = {31'd0, sh_en[i]}; end
              default: ;
            endcase
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      reg_rd_resp <= 1'b0;
      reg_rd_data <= 32'd0;
    end else begin
      reg_rd_resp <= reg_rd_req && rd_hit;
      reg_rd_data <= (reg_rd_req && rd_hit) ? rd_val : 32'd0;
    end
  end

  // ---------------- Lookup ----------------
  logic       any_hit, any_mac;
  logic [2:0] first_idx;

  always_comb begin
    any_hit   = 1'b0;
    any_mac   = &lkp_mac;   // broadcast always counts as a MAC hit
    first_idx = 3'd0;
    for (int i = 0; i < NUM_IDS; i++) begin
      if (act_en[i] && (act_mac[i] == lkp_mac)) begin
        any_mac = 1'b1;
        if ((act_ip[i] == lkp_ip) && (act_udp[i] == lkp_udp)) begin
          if (!any_hit) first_idx = 3'(i);
          any_hit = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lkp_resp    <= 1'b0;
      lkp_hit     <= 1'b0;
      lkp_mac_hit <= 1'b0;
      lkp_idx     <= 3'd0;
    end else begin
      lkp_resp <= lkp_req;
      if (lkp_req) begin
        lkp_hit     <= any_hit;
        lkp_mac_hit <= any_mac;
        lkp_idx     <= first_idx;
      end
    end
  end

  // ---------------- Flattened active table ----------------
  for (genvar g = 0; g < NUM_IDS; g++) begin : g_flat
    assign active_mac[g*48 +: 48] = act_mac[g];
    assign active_ip[g*32 +: 32]  = act_ip[g];
    assign active_udp[g*16 +: 16] = act_udp[g];
  end
  assign active_en = act_en;

endmodule
